// File: rtl/bus_out_arbiter_if.sv
// Bus-drive request/grant bundle between the datapath sources and the
// bus_out_arbiter.
//   req          32  bus requests, bit index = source number
//   lock         1   current owner asks to keep the bus
//   stall        1   freeze arbiter state and outputs
//   grant        32  registered one-hot *Out strobes (zero when idle)
//   grant_idx    5   binary index of the set grant bit (0 when idle)
//   grant_valid  1   grant is nonzero
//   lock_timeout 1   one-cycle pulse when a lock is forcibly ended
// master: request side; slave: arbiter side.
interface bus_out_arbiter_if;
  logic [31:0] req;
  logic        lock;
  logic        stall;
  logic [31:0] grant;
  logic [4:0]  grant_idx;
  logic        grant_valid;
  logic        lock_timeout;

  modport master (
    output req, lock, stall,
    input  grant, grant_idx, grant_valid, lock_timeout
  );

  modport slave (
    input  req, lock, stall,
    output grant, grant_idx, grant_valid, lock_timeout
  );
endinterface

// File: rtl/bus_out_arbiter.sv
// bus_out_arbiter: picks one of 32 bus-drive requesters per cycle and
// issues a registered one-hot grant to the 32:5 bus-select encoder.
// Supports bounded multi-cycle ownership (lock) and a global stall.
// Ports:
//   clock  rising-edge clock
//   clear  synchronous active-high reset (dominates stall)
//   bus    bus_out_arbiter_if.slave (req/lock/stall in; grant,
//          grant_idx, grant_valid, lock_timeout out, all registered)
// Parameter MAX_LOCK (1..255): extra cycles a locked owner may hold.
// Macro BUS_ARB_ROUND_ROBIN_EN: defined -> round-robin search starting
// below the last winner; undefined -> fixed priority, highest index wins.
module bus_out_arbiter #(
  parameter int unsigned MAX_LOCK = 15
) (
  input logic              clock,
  input logic              clear,
  bus_out_arbiter_if.slave bus
);

  localparam int unsigned NREQ = 32;
  localparam int unsigned IDXW = 5;
  localparam int unsigned CNTW = 8;

  typedef enum logic [1:0] {IDLE, GRANT, LOCK} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              lto_q, lto_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [IDXW-1:0]   start_c;
`endif

  logic              do_arb_c;
  logic              forced_c;
  logic [NREQ-1:0]   req_m_c;
  logic              found_c;
  logic [IDXW-1:0]   win_c;

  // State and output registers.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      lto_q   <= 1'b0;
      owner_q <= '0;
      cnt_q   <= '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      lto_q   <= lto_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Next-state, arbitration and output logic.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    lto_d    = 1'b0;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    ptr_d    = ptr_q;
    start_c  = IDXW'(ptr_q - IDXW'(1));
`endif
    do_arb_c = 1'b0;
    forced_c = 1'b0;
    found_c  = 1'b0;
    win_c    = '0;

    if (!bus.stall) begin
      unique case (state_q)
        IDLE: do_arb_c = 1'b1;
        GRANT: begin
          if (bus.lock && bus.req[owner_q]) begin
            state_d = LOCK;
            cnt_d   = CNTW'(1);
          end else begin
            do_arb_c = 1'b1;
          end
        end
        LOCK: begin
          if (bus.lock && bus.req[owner_q]) begin
            if (cnt_q < CNTW'(MAX_LOCK)) begin
              cnt_d = CNTW'(cnt_q + CNTW'(1));
            end else begin
              forced_c = 1'b1;
              do_arb_c = 1'b1;
              lto_d    = 1'b1;
            end
          end else begin
            do_arb_c = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A forced release hides the owner from this one decision only.
    req_m_c = bus.req & ~(forced_c ? (NREQ'(1) << owner_q) : '0);

    // Later loop iterations override earlier ones, so the last hit is the
    // highest-priority candidate.
`ifdef BUS_ARB_ROUND_ROBIN_EN
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_m_c[IDXW'(start_c - IDXW'(k))]) begin
        found_c = 1'b1;
        win_c   = IDXW'(start_c - IDXW'(k));
      end
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      if (req_m_c[k]) begin
        found_c = 1'b1;
        win_c   = IDXW'(k);
      end
    end
`endif

    if (do_arb_c) begin
      cnt_d = '0;
      if (found_c) begin
        state_d = GRANT;
        grant_d = NREQ'(1) << win_c;
        idx_d   = win_c;
        valid_d = 1'b1;
        owner_d = win_c;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        ptr_d   = win_c;
`endif
      end else begin
        state_d = IDLE;
        grant_d = '0;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    end
  end

  assign bus.grant        = grant_q;
  assign bus.grant_idx    = idx_q;
  assign bus.grant_valid  = valid_q;
  assign bus.lock_timeout = lto_q;

endmodule

// File: tb/tb_bus_out_arbiter.sv
module tb_bus_out_arbiter;

  logic clock;
  logic clear;
  int   n_cmp;
  int   n_bad;

  bus_out_arbiter_if bus_if ();

  bus_out_arbiter #(.MAX_LOCK(4)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check grant / grant_idx / grant_valid / lock_timeout together.
  task automatic chk_g(input string tag, input bit active, input logic [4:0] idx, input logic lto);
    logic [31:0] g;
    g = active ? (32'd1 << idx) : 32'd0;
    chk({tag, ".grant"}, bus_if.grant, g);
    chk({tag, ".idx"}, 32'(bus_if.grant_idx), active ? 32'(idx) : 32'd0);
    chk({tag, ".valid"}, 32'(bus_if.grant_valid), 32'(active));
    chk({tag, ".lto"}, 32'(bus_if.lock_timeout), 32'(lto));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    logic [4:0] e3 [5];
    n_cmp = 0;
    n_bad = 0;
    clear = 1'b0;
    bus_if.req   = '0;
    bus_if.lock  = 1'b0;
    bus_if.stall = 1'b0;

    // Reset state and basic grant.
    do_clear();
    chk_g("reset", 1'b0, 5'd0, 1'b0);
    tick();
    chk_g("idle_noreq", 1'b0, 5'd0, 1'b0);
    bus_if.req = 32'h0010_0000;
    tick();
    chk_g("basic_pc", 1'b1, 5'd20, 1'b0);
    bus_if.req = '0;
    tick();
    chk_g("basic_drop", 1'b0, 5'd0, 1'b0);

    // Three-way contention.
    do_clear();
    e3[0] = 5'd31; e3[1] = 5'd5; e3[2] = 5'd0; e3[3] = 5'd31; e3[4] = 5'd5;
    bus_if.req = 32'h8000_0021;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_g($sformatf("three_way[%0d]", i), 1'b1, RR ? e3[i] : 5'd31, 1'b0);
    end

    // Lock timeout with a competing requester.
    do_clear();
    bus_if.req  = 32'h0020_0008;
    bus_if.lock = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_g($sformatf("lock_hold[%0d]", i), 1'b1, 5'd21, 1'b0);
    end
    tick();
    chk_g("lock_forced", 1'b1, 5'd3, 1'b1);
    tick();
    chk_g("lock_new_owner", 1'b1, 5'd3, 1'b0);
    bus_if.lock = 1'b0;

    // Forced release with no other requester goes idle, then regrants.
    do_clear();
    bus_if.req  = 32'h0000_0080;
    bus_if.lock = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk_g("solo_held", 1'b1, 5'd7, 1'b0);
    tick();
    chk_g("solo_forced_idle", 1'b0, 5'd0, 1'b1);
    tick();
    chk_g("solo_regrant", 1'b1, 5'd7, 1'b0);
    bus_if.lock = 1'b0;

    // Stall freezes grant and pointer.
    do_clear();
    bus_if.req = 32'hFFFF_FFFF;
    tick();
    chk_g("stall_pre0", 1'b1, 5'd31, 1'b0);
    tick();
    chk_g("stall_pre1", 1'b1, RR ? 5'd30 : 5'd31, 1'b0);
    bus_if.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_g($sformatf("stall_hold[%0d]", i), 1'b1, RR ? 5'd30 : 5'd31, 1'b0);
    end
    bus_if.stall = 1'b0;
    tick();
    chk_g("stall_post", 1'b1, RR ? 5'd29 : 5'd31, 1'b0);

    // Clear during lock while stalled.
    do_clear();
    bus_if.req  = 32'h0000_0010;
    bus_if.lock = 1'b1;
    tick();
    chk_g("ml_grant", 1'b1, 5'd4, 1'b0);
    tick();
    chk_g("ml_lock", 1'b1, 5'd4, 1'b0);
    bus_if.stall = 1'b1;
    clear = 1'b1;
    tick();
    chk_g("ml_cleared", 1'b0, 5'd0, 1'b0);
    clear = 1'b0;
    bus_if.stall = 1'b0;
    bus_if.lock  = 1'b0;
    bus_if.req   = 32'hFFFF_FFFF;
    tick();
    chk_g("ml_restart", 1'b1, 5'd31, 1'b0);

    // Full sweep.
    do_clear();
    bus_if.req = 32'hFFFF_FFFF;
    for (int i = 0; i < 32; i++) begin
      tick();
      chk_g($sformatf("sweep[%0d]", i), 1'b1, RR ? 5'(31 - i) : 5'd31, 1'b0);
    end

    bus_if.req = '0;
    tick();
    chk_g("final_idle", 1'b0, 5'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_out_arbiter.md
# bus_out_arbiter

Sequential arbiter sitting directly upstream of the 32:5 bus-select encoder. Collects bus-drive requests from the 32 datapath sources and issues exactly one registered one-hot `*Out` strobe per cycle, so the encoder and the bus multiplexer never see overlapping drivers. Supports multi-cycle bus ownership (lock) with a bounded hold and a global stall that freezes the bus during memory waits.

## Interface
- `MAX_LOCK`, 15: maximum extra cycles a locked owner may keep the bus, range 1–255.
- `clock`  in  1  rising-edge clock.
- `clear`  in  1  synchronous, active-high reset.
- `req`  in  32  bus requests; bit index = source number (0–15 R0–R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 InPort, 23 C, 24–31 R24–R31).
- `lock`  in  1  current owner asks to keep the bus.
- `stall`  in  1  freeze all arbiter state and outputs.
- `grant`  out  32  registered one-hot `*Out` strobes to the encoder; zero when idle.
- `grant_idx`  out  5  binary index of the set `grant` bit; 0 when idle.
- `grant_valid`  out  1  `grant` is nonzero.
- `lock_timeout`  out  1  one-cycle pulse when a lock is forcibly ended.

## Operation
- States: IDLE, GRANT, LOCK. Internal: `owner` (5 b), `ptr` (5 b, last winner), `lock_cnt` (8 b).
- Arbitration: round-robin search starting at `ptr-1`, descending, wrapping 0→31. With `ptr`=0 after clear, the first search starts at 31, i.e. highest index.
- IDLE: if `req`≠0, go to GRANT. Set `grant` to the one-hot of the winner, set `owner` and `ptr` to the winner. Otherwise stay in IDLE with `grant`=0.
- GRANT, with `lock`=1 and `req[owner]`=1: go to LOCK, hold `grant`, set `lock_cnt`=1.
- GRANT, otherwise: arbitrate again and stay in GRANT if any request exists, else go to IDLE. The current owner takes its normal round-robin position.
- LOCK, with `lock`=1, `req[owner]`=1 and `lock_cnt`<`MAX_LOCK`: hold `grant`, increment `lock_cnt`.
- LOCK, with `lock`=1, `req[owner]`=1 and `lock_cnt`=`MAX_LOCK`: forced release.
  - Arbitrate with `owner` masked out for this one decision.
  - Pulse `lock_timeout`.
  - Go to GRANT, or to IDLE if nothing else is requesting.
- LOCK, with `lock` or `req[owner]` low: normal release, arbitrate as from GRANT.
- `stall`=1 holds state, `grant`, `ptr`, `owner` and `lock_cnt`; `lock_timeout` is 0. Requests seen during a stall are evaluated on the first unstalled edge.
- A dropped `req` never truncates the current grant cycle. It only affects the next decision.
- `grant` is always zero or one-hot. `grant_idx` always equals the encoder's output for that `grant`.

## Timing
- All outputs are registered. A `req` sampled at edge n is reflected in `grant` after edge n, so latency is 1 cycle.
- Each grant lasts at least 1 cycle. A locked owner holds the bus for at most 1+`MAX_LOCK` consecutive unstalled cycles.
- `lock_timeout` is high in the same cycle as the first grant after a forced release.
- Reset values, one edge after `clear`=1: state IDLE, `grant`=0, `grant_idx`=0, `grant_valid`=0, `lock_timeout`=0, `ptr`=0, `owner`=0, `lock_cnt`=0.
- `clear` dominates `stall` and all other inputs, including mid-lock.

## Configuration
- `BUS_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration as described above.
- `BUS_ARB_ROUND_ROBIN_EN` undefined: fixed priority, highest requesting index wins every decision. The encoder's priority order is kept; `ptr` is removed.
  - A forced release still masks the owner for one decision.

## Test plan
- Basic grant: `clear`, then `req`=0 → `grant`=0, `grant_valid`=0. Set `req`=0x0010_0000 at edge n → after edge n, `grant`=0x0010_0000, `grant_idx`=20, then IDLE the cycle after the request drops.
- Three-way contention: `req`=0x8000_0021 held.
  - Round-robin build: `grant_idx` sequence 31, 5, 0, 31, ….
  - Fixed-priority build: 31 every cycle.
- Lock timeout: `MAX_LOCK`=4, `req`=0x0020_0008, `lock`=1 held.
  - Bit 21 is granted first and held for 5 cycles.
  - Next cycle: `grant_idx`=3 with `lock_timeout`=1.
- Stall: `stall`=1 for 3 cycles during a GRANT with `req`=0xFFFF_FFFF → `grant` frozen and no `ptr` advance. After the stall, the next index down is granted.
- Clear mid-lock: `clear`=1 during LOCK with `stall`=1 → next cycle all outputs 0; the next request restarts from index 31.
- Full sweep: `req`=0xFFFF_FFFF for 32 unstalled cycles (round-robin build) → each index granted exactly once, in order 31 down to 0.
